// File: rtl/ah_cam_req_arb_if.sv
// Requester/CAM bundle for ah_cam_req_arb.
// The arbiter uses the slave modport; requesters and the CAM sit on the master side.
interface ah_cam_req_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned KW    = 8,
  parameter int unsigned DEPTH = 10
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_match;
  logic [DW-1:0]      rsp_data;
  logic               cam_wvalid;
  logic [DW-1:0]      cam_wdata;
  logic               cam_wready;
  logic               cam_svalid;
  logic [KW-1:0]      cam_skey;
  logic               cam_rvalid;
  logic               cam_rmatch;
  logic [DW-1:0]      cam_rdata;
  logic               cam_free;
  logic [CW-1:0]      free_cnt;
  logic               err;

  modport master (
    output req_valid, req_op, req_data, cam_wready, cam_rvalid, cam_rmatch, cam_rdata,
           cam_free,
    input  req_ready, rsp_valid, rsp_match, rsp_data, cam_wvalid, cam_wdata, cam_svalid,
           cam_skey, free_cnt, err
  );

  modport slave (
    input  req_valid, req_op, req_data, cam_wready, cam_rvalid, cam_rmatch, cam_rdata,
           cam_free,
    output req_ready, rsp_valid, rsp_match, rsp_data, cam_wvalid, cam_wdata, cam_svalid,
           cam_skey, free_cnt, err
  );
endinterface

// File: rtl/ah_cam_req_arb.sv
// Round-robin arbiter sharing one CAM between NREQ requesters: writes gated by free-entry
// count, searches tagged through a SLAT-deep pipeline so results return to their requester.
module ah_cam_req_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned KW    = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned SLAT  = 1
) (
  input logic             clk,
  input logic             rst,
  ah_cam_req_arb_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   free_cnt_q, free_cnt_d;
  logic [SLAT-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0]   tag_idx_q [SLAT];
  logic [IW-1:0]   tag_idx_d [SLAT];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_match_q, rsp_match_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   scan_idx;
  logic            gnt_op;
  logic [DW-1:0]   gnt_data;
  logic            wr_acc;
  logic            srch;

  // Reset gates eligibility so no grant or CAM strobe escapes while rst is high.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = ~rst & bus.req_valid[i] &
                (bus.req_op[i] | ((free_cnt_q != '0) & bus.cam_wready));
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IW'((32'(rr_ptr_q) + k) % NREQ);
      if (!gnt_found && elig[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i] = gnt_found && (gnt_idx == IW'(i));
    end
    gnt_op   = bus.req_op[gnt_idx];
    gnt_data = bus.req_data[32'(gnt_idx) * DW +: DW];
    wr_acc   = gnt_found & ~gnt_op;
    srch     = gnt_found & gnt_op;
  end

  assign bus.req_ready  = gnt;
  assign bus.cam_wvalid = wr_acc;
  assign bus.cam_wdata  = gnt_data;
  assign bus.cam_svalid = srch;
  assign bus.cam_skey   = gnt_data[KW-1:0];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // A granted write is already known to have cam_wready, so it is always accepted.
  always_comb begin
    free_cnt_d  = free_cnt_q;
    err_d       = err_q;
    tag_v_d     = tag_v_q;
    tag_idx_d   = tag_idx_q;
    rsp_valid_d = '0;
    rsp_match_d = rsp_match_q;
    rsp_data_d  = rsp_data_q;

    if (wr_acc && !bus.cam_free) begin
      free_cnt_d = free_cnt_q - 1'b1;
    end else if (!wr_acc && bus.cam_free) begin
      if (free_cnt_q == CW'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        free_cnt_d = free_cnt_q + 1'b1;
      end
    end

    tag_v_d[0]   = srch;
    tag_idx_d[0] = gnt_idx;
    for (int unsigned s = 1; s < SLAT; s++) begin
      tag_v_d[s]   = tag_v_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    // Result and tag must arrive together; either one alone is a protocol error.
    if (bus.cam_rvalid && tag_v_q[SLAT-1]) begin
      rsp_valid_d = NREQ'(1) << tag_idx_q[SLAT-1];
      rsp_match_d = bus.cam_rmatch;
      rsp_data_d  = bus.cam_rdata;
    end
    if (bus.cam_rvalid != tag_v_q[SLAT-1]) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      free_cnt_q  <= CW'(DEPTH);
      tag_v_q     <= '0;
      for (int unsigned s = 0; s < SLAT; s++) begin
        tag_idx_q[s] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_match_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      free_cnt_q  <= free_cnt_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_match_q <= rsp_match_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_match = rsp_match_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.free_cnt  = free_cnt_q;
  assign bus.err       = err_q;
endmodule
